// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared CPU widths for the write-back path
package regfile_wb_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam int WB_NREQ = 3;
  localparam int WB_SW = (WB_NREQ > 1) ? $clog2(WB_NREQ) : 1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick starting at ptr, one-hot plus index
module rr_picker #(
  parameter int N = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    // walk from farthest to nearest so the closest request to ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int AW = REG_AW,
  parameter int DW = DATA_W,
  parameter int SW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic [SW-1:0]    wb_src
);
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   idx;
  logic [NREQ-1:0] pick;
  logic            grant;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_picker #(.N(NREQ), .IW(SW)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .gnt(pick),
    .idx(idx)
  );

  assign gnt = (stall || rst) ? '0 : pick;
  assign grant = |gnt;
  assign sel_addr = req_addr[int'(idx)*AW +: AW];
  assign sel_data = req_data[int'(idx)*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      wb_en <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_src <= '0;
    end else if (grant) begin
      rr_ptr <= (idx == SW'(NREQ - 1)) ? '0 : idx + 1'b1;
      wb_en <= sel_addr != AW'(0);
      wb_addr <= sel_addr;
      wb_data <= sel_data;
      wb_src <= idx;
    end else begin
      wb_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grant order, latency, r0, stall, reset
module tb_regfile_wb_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic        stall = 0;
  logic [2:0]  req = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  gnt;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  wb_src;
  int checks = 0;
  int fails = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++; if (wb_en !== 1'b0) begin fails++; $display("FAIL init_wb_en got %b want 0", wb_en); end
    checks++; if (wb_data !== 32'h0) begin fails++; $display("FAIL init_wb_data got %h want 0", wb_data); end
    rst = 0;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'hC3, 32'hB2, 32'hA1};
    req = 3'b111;
    #1;
    checks++; if (gnt !== 3'b001) begin fails++; $display("FAIL rst_first_gnt got %b want 001", gnt); end
    tick();
    checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd1) begin fails++; $display("FAIL pre_rst_write got en=%b addr=%0d want en=1 addr=1", wb_en, wb_addr); end
    #2 rst = 1;
    #1;
    checks++; if (wb_en !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'h0) begin fails++; $display("FAIL async_rst got en=%b addr=%0d data=%h want 0/0/0", wb_en, wb_addr, wb_data); end
    checks++; if (gnt !== 3'b000) begin fails++; $display("FAIL rst_gnt got %b want 000", gnt); end
    tick();
    rst = 0;
    #1;
    checks++; if (gnt !== 3'b001) begin fails++; $display("FAIL post_rst_gnt got %b want 001", gnt); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_single;
    req_addr[9:5] = 5'd8;
    req_data[63:32] = 32'hDEADBEEF;
    req = 3'b010;
    #1;
    checks++; if (gnt !== 3'b010) begin fails++; $display("FAIL single_gnt got %b want 010", gnt); end
    tick();
    req = 3'b000;
    checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd8 || wb_data !== 32'hDEADBEEF || wb_src !== 2'd1) begin fails++; $display("FAIL single_wb got en=%b addr=%0d data=%h src=%0d want 1/8/deadbeef/1", wb_en, wb_addr, wb_data, wb_src); end
    tick();
    checks++; if (wb_en !== 1'b0 || wb_addr !== 5'd8 || wb_src !== 2'd1) begin fails++; $display("FAIL idle_hold got en=%b addr=%0d src=%0d want 0/8/1", wb_en, wb_addr, wb_src); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_g [6];
    logic [1:0] exp_s [6];
    logic [31:0] dv [3];
    exp_g = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    exp_s = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    dv = '{32'hA1, 32'hB2, 32'hC3};
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'hC3, 32'hB2, 32'hA1};
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (gnt !== exp_g[i]) begin fails++; $display("FAIL rr_gnt[%0d] got %b want %b", i, gnt, exp_g[i]); end
      tick();
      checks++; if (wb_en !== 1'b1 || wb_src !== exp_s[i] || wb_data !== dv[exp_s[i]]) begin fails++; $display("FAIL rr_wb[%0d] got en=%b src=%0d data=%h want en=1 src=%0d data=%h", i, wb_en, wb_src, wb_data, exp_s[i], dv[exp_s[i]]); end
    end
    req = 3'b000;
  endtask

  task automatic test_r0;
    req_addr[4:0] = 5'd0;
    req_data[31:0] = 32'h1;
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin fails++; $display("FAIL r0_gnt got %b want 001", gnt); end
    tick();
    checks++; if (wb_en !== 1'b0 || wb_src !== 2'd0) begin fails++; $display("FAIL r0_wb got en=%b src=%0d want 0/0", wb_en, wb_src); end
    req = 3'b011;
    #1;
    checks++; if (gnt !== 3'b010) begin fails++; $display("FAIL r0_next_gnt got %b want 010", gnt); end
    tick();
    checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd2) begin fails++; $display("FAIL r0_next_wb got en=%b addr=%0d want 1/2", wb_en, wb_addr); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_stall;
    req_addr[4:0] = 5'd1;
    stall = 1;
    req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gnt !== 3'b000) begin fails++; $display("FAIL stall_gnt[%0d] got %b want 000", i, gnt); end
      tick();
      checks++; if (wb_en !== 1'b0) begin fails++; $display("FAIL stall_wb[%0d] got %b want 0", i, wb_en); end
    end
    stall = 0;
    #1;
    checks++; if (gnt !== 3'b100) begin fails++; $display("FAIL unstall_gnt got %b want 100", gnt); end
    tick();
    stall = 1;
    #1;
    checks++; if (wb_en !== 1'b1 || wb_src !== 2'd2 || gnt !== 3'b000) begin fails++; $display("FAIL stall_mid got en=%b src=%0d gnt=%b want 1/2/000", wb_en, wb_src, gnt); end
    tick();
    checks++; if (wb_en !== 1'b0) begin fails++; $display("FAIL stall_mid_next got %b want 0", wb_en); end
    stall = 0;
    #1;
    checks++; if (gnt !== 3'b001) begin fails++; $display("FAIL unstall_gnt2 got %b want 001", gnt); end
    tick();
    req = 3'b000;
    tick();
  endtask

  task automatic test_wrap;
    req = 3'b010;
    tick();
    req = 3'b011;
    #1;
    checks++; if (gnt !== 3'b001) begin fails++; $display("FAIL wrap_gnt got %b want 001", gnt); end
    tick();
    checks++; if (wb_src !== 2'd0 || wb_en !== 1'b1) begin fails++; $display("FAIL wrap_wb got src=%0d en=%b want 0/1", wb_src, wb_en); end
    checks++; if (gnt !== 3'b010) begin fails++; $display("FAIL wrap_gnt2 got %b want 010", gnt); end
    tick();
    checks++; if (wb_src !== 2'd1) begin fails++; $display("FAIL wrap_wb2 got src=%0d want 1", wb_src); end
    req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_r0();
    test_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
